dag_op_arbiter: RTL and testbench

DAG_OP_ARBITER -- requirements
Module: dag_op_arbiter

---
 rtl/dag_sched_pkg.sv | 23 ++
 rtl/dag_rr_pick.sv | 42 ++++
 rtl/dag_op_arbiter.sv | 118 +++++++++++
 tb/tb_dag_op_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dag_sched_pkg.sv
// Shared constants and types for the DAG operation scheduler: requester count,
// id width, default operand width and the opcode encoding.
package dag_sched_pkg;

    localparam int BITS_DEFAULT = 2;
    localparam int NREQ         = 4;
    localparam int ID_W         = 2;

    typedef enum logic {
        OP_AND  = 1'b0,
        OP_XAND = 1'b1
    } op_e;

    // Result of one operation: a&b, or a^(a&b) for the XOR-of-AND opcode.
    function automatic logic [BITS_DEFAULT-1:0] op_eval(
        input op_e                    opc,
        input logic [BITS_DEFAULT-1:0] a,
        input logic [BITS_DEFAULT-1:0] and_ab
    );
        return (opc == OP_XAND) ? (a ^ and_ab) : and_ab;
    endfunction

endpackage

// File: rtl/dag_rr_pick.sv
// Round-robin picker: first requester at or after rr_ptr (mod NREQ) wins.
// Purely combinational; en=0 suppresses every grant.
module dag_rr_pick
    import dag_sched_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [NREQ-1:0] rot_req;
    logic [ID_W-1:0] off;

    // rot_req[k] is the request sitting k places after the pointer.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            assign rot_req[gi] = req[rr_ptr + ID_W'(gi)];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                off = ID_W'(k);
            end
        end
    end

    assign any = en & (|rot_req);
    assign idx = rr_ptr + off;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
            assign grant[gi] = any && (idx == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/dag_op_arbiter.sv
// Round-robin arbiter feeding a two-stage AND / XOR-of-AND pipeline.
// Grant is combinational; the result appears two clocks after the grant cycle.
module dag_op_arbiter
    import dag_sched_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT,
    parameter int NREQ = dag_sched_pkg::NREQ
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*BITS-1:0] a_in,
    input  logic [NREQ*BITS-1:0] b_in,
    input  logic                 pause,
    output logic [NREQ-1:0]      grant,
    output logic                 out_valid,
    output logic [ID_W-1:0]      out_id,
    output logic [BITS-1:0]      out_data,
    output logic                 busy,
    output logic [7:0]           done_cnt
);

    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] pick_idx;
    logic            pick_any;
    logic [NREQ-1:0] pick_grant;

    logic            s1_v_q, s1_v_d;
    op_e             s1_op_q, s1_op_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic [BITS-1:0] s1_a_q, s1_a_d;
    logic [BITS-1:0] s1_and_q, s1_and_d;

    logic            out_valid_q, out_valid_d;
    logic [ID_W-1:0] out_id_q, out_id_d;
    logic [BITS-1:0] out_data_q, out_data_d;
    logic [7:0]      done_q, done_d;

    logic [BITS-1:0] a_arr [NREQ];
    logic [BITS-1:0] b_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_arr[gi] = a_in[gi*BITS +: BITS];
            assign b_arr[gi] = b_in[gi*BITS +: BITS];
        end
    endgenerate

    // Reset blocks grants in the same cycle, so nothing is captured then.
    dag_rr_pick u_pick (
        .req    (req),
        .rr_ptr (rr_q),
        .en     (~pause & ~reset),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign grant = pick_grant;

    always_comb begin
        rr_d        = rr_q;
        s1_v_d      = pick_any;
        s1_op_d     = s1_op_q;
        s1_id_d     = s1_id_q;
        s1_a_d      = s1_a_q;
        s1_and_d    = s1_and_q;
        out_valid_d = s1_v_q;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        done_d      = done_q + {7'd0, out_valid_q};
        if (pick_any) begin
            rr_d     = pick_idx + 1'b1;
            s1_op_d  = op_e'(op[pick_idx]);
            s1_id_d  = pick_idx;
            s1_a_d   = a_arr[pick_idx];
            s1_and_d = a_arr[pick_idx] & b_arr[pick_idx];
        end
        if (s1_v_q) begin
            out_id_d   = s1_id_q;
            out_data_d = (s1_op_q == OP_XAND) ? (s1_a_q ^ s1_and_q) : s1_and_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q        <= '0;
            s1_v_q      <= 1'b0;
            s1_op_q     <= OP_AND;
            s1_id_q     <= '0;
            s1_a_q      <= '0;
            s1_and_q    <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            done_q      <= '0;
        end else begin
            rr_q        <= rr_d;
            s1_v_q      <= s1_v_d;
            s1_op_q     <= s1_op_d;
            s1_id_q     <= s1_id_d;
            s1_a_q      <= s1_a_d;
            s1_and_q    <= s1_and_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_data  = out_data_q;
    assign done_cnt  = done_q;
    assign busy      = s1_v_q | out_valid_q;

endmodule

// File: tb/tb_dag_op_arbiter.sv
// Bench for dag_op_arbiter: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of grants, results and counters.
module tb_dag_op_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       pause;
    logic [3:0] req;
    logic [3:0] op;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [3:0] grant;
    logic       out_valid;
    logic [1:0] out_id;
    logic [1:0] out_data;
    logic       busy;
    logic [7:0] done_cnt;

    dag_op_arbiter #(.BITS(2), .NREQ(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .pause     (pause),
        .grant     (grant),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_data  (out_data),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int due;
        int id;
        int data;
    } exp_t;

    exp_t       pend[$];
    int         rr_m;
    int         cnt_m;
    int         cyc;
    int         total;
    int         bad;
    logic [3:0] last_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, expv, cyc);
        end
    endtask

    // One clock: compare at the falling edge, advance the model, move past the rising edge.
    task automatic step();
        int         g;
        int         av, bv, andv, res;
        logic [3:0] gexp;
        logic       ov_exp;
        exp_t       e;
        @(negedge clock);
        g    = -1;
        gexp = 4'd0;
        if (!reset && !pause) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (rr_m + k) % 4;
                if (req[c] && g < 0) g = c;
            end
        end
        if (g >= 0) gexp[g] = 1'b1;
        chk("grant", {28'd0, grant}, {28'd0, gexp});
        ov_exp = (pend.size() > 0) && (pend[0].due == cyc);
        chk("busy", {31'd0, busy}, {31'd0, pend.size() > 0});
        chk("out_valid", {31'd0, out_valid}, {31'd0, ov_exp});
        chk("done_cnt", {24'd0, done_cnt}, cnt_m);
        if (ov_exp) begin
            e = pend.pop_front();
            chk("out_id", {30'd0, out_id}, e.id);
            chk("out_data", {30'd0, out_data}, e.data);
        end
        if (reset) begin
            pend.delete();
            cnt_m = 0;
            rr_m  = 0;
        end else begin
            if (ov_exp) cnt_m = (cnt_m + 1) % 256;
            if (g >= 0) begin
                av   = int'(a_in[g*2 +: 2]);
                bv   = int'(b_in[g*2 +: 2]);
                andv = av & bv;
                res  = op[g] ? (av ^ andv) : andv;
                pend.push_back('{due: cyc + 2, id: g, data: res});
                rr_m = (g + 1) % 4;
            end
        end
        last_grant = gexp;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; rr_m = 0; cnt_m = 0; last_grant = 4'd0;
        reset = 1'b1; pause = 1'b0; req = 4'd0; op = 4'd0; a_in = 8'd0; b_in = 8'd0;
        steps(3);
        reset = 1'b0;
        step();
        chk("rst_out_id", {30'd0, out_id}, 0);
        chk("rst_out_data", {30'd0, out_data}, 0);

        // Single AND request on requester 0.
        req = 4'b0001; op = 4'b0000; a_in = 8'b0000_0011; b_in = 8'b0000_0010;
        #1 chk("single_grant", {28'd0, grant}, 32'b0001);
        step();
        req = 4'd0;
        step();
        chk("single_valid", {31'd0, out_valid}, 1);
        chk("single_id", {30'd0, out_id}, 0);
        chk("single_data", {30'd0, out_data}, 32'b10);
        steps(2);

        // XOR-of-AND on requester 2.
        req = 4'b0100; op = 4'b0100; a_in = 8'b0011_0000; b_in = 8'b0001_0000;
        step();
        req = 4'd0;
        step();
        chk("xand_valid", {31'd0, out_valid}, 1);
        chk("xand_id", {30'd0, out_id}, 2);
        chk("xand_data", {30'd0, out_data}, 32'b10);
        steps(2);

        // Land the pointer on 0, then hold all requests for eight cycles.
        req = 4'b1000;
        step();
        req = 4'b1111; op = 4'b1010; a_in = 8'hE4; b_in = 8'h9C;
        for (int k = 0; k < 8; k++) begin
            #1 chk("rotate_grant", {28'd0, grant}, 32'd1 << (k % 4));
            step();
        end

        // Pause with requests pending: pipeline drains, pointer holds.
        pause = 1'b1;
        steps(2);
        chk("pause_busy", {31'd0, busy}, 0);
        steps(2);
        pause = 1'b0;
        #1 chk("resume_grant", {28'd0, grant}, 32'b0001);
        step();
        req = 4'd0;
        steps(3);

        // Reset one cycle after a grant discards the op.
        req = 4'b0010; a_in = 8'hFF; b_in = 8'hFF;
        step();
        req = 4'd0; reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("mid_reset_valid", {31'd0, out_valid}, 0);
            step();
        end
        chk("mid_reset_cnt", {24'd0, done_cnt}, 0);
        req = 4'b1111;
        #1 chk("mid_reset_ptr", {28'd0, grant}, 32'b0001);
        step();
        req = 4'd0;
        steps(3);

        // Random traffic; a request stays up until it has been granted.
        for (int i = 0; i < 300; i++) begin
            req   = (req & ~last_grant) | 4'($urandom_range(0, 15));
            op    = 4'($urandom);
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            pause = ($urandom_range(0, 9) == 0);
            step();
        end
        req = 4'd0; pause = 1'b0;
        steps(3);

        // 256 completions wrap the counter back to zero.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 256; i++) begin
            op   = 4'($urandom);
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            step();
        end
        req = 4'd0;
        step();
        chk("wrap_cnt_255", {24'd0, done_cnt}, 255);
        step();
        chk("wrap_cnt_0", {24'd0, done_cnt}, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
